// File: rtl/awb_gain_est_pkg.sv
// Shared types and defaults for the gray-world AWB gain estimator.
package awb_pkg;

  typedef enum logic [1:0] {
    RED   = 2'd0,
    GREEN = 2'd1,
    BLUE  = 2'd2,
    NOCOL = 2'd3
  } awb_color_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MUL    = 3'd1,
    ST_DIV_R  = 3'd2,
    ST_DIV_B  = 3'd3,
    ST_COMMIT = 3'd4
  } awb_state_e;

  localparam int DEF_ACC_W     = 24;
  localparam int DEF_CNT_W     = 16;
  localparam int DEF_GAIN_W    = 8;
  localparam int DEF_FRAC_BITS = 0;
  localparam int UNITY_GAIN    = 1 << DEF_FRAC_BITS;

  function automatic int unity_gain(input int frac_bits);
    return 1 << frac_bits;
  endfunction

endpackage

// File: rtl/awb_gain_est_if.sv
// Bayer pixel stream with frame delimiters feeding the AWB estimator.
interface awb_gain_est_if;
  logic       valid_i;
  logic [1:0] color_i;
  logic [7:0] value_i;
  logic       frame_start_i;
  logic       frame_end_i;

  modport master (output valid_i, color_i, value_i, frame_start_i, frame_end_i);
  modport slave  (input  valid_i, color_i, value_i, frame_start_i, frame_end_i);
endinterface

// File: rtl/awb_gain_est_div.sv
// Restoring divider: one setup cycle then Q_W iterations; saturates to all-ones
// when den==0 or the quotient would not fit in Q_W bits.
module awb_div #(
  parameter int NUM_W = 40,
  parameter int DEN_W = 40,
  parameter int Q_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [NUM_W-1:0] num_i,
  input  logic [DEN_W-1:0] den_i,
  output logic             done_o,
  output logic [Q_W-1:0]   quo_o
);
  localparam int W  = (NUM_W > DEN_W + Q_W) ? NUM_W : DEN_W + Q_W;
  localparam int CW = $clog2(Q_W + 1);

  logic [W-1:0]   rem_q, dsh_q;
  logic [Q_W-1:0] quo_q;
  logic [CW-1:0]  cnt_q;
  logic           run_q, sat_q, done_q;
  logic           ge;

  assign ge     = (rem_q >= dsh_q);
  assign done_o = done_q;
  assign quo_o  = quo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= '0;
      dsh_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      sat_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q <= W'(num_i);
        dsh_q <= W'(den_i) << (Q_W - 1);
        quo_q <= '0;
        cnt_q <= CW'(Q_W);
        run_q <= 1'b1;
        sat_q <= (den_i == '0) || (W'(num_i) >= (W'(den_i) << Q_W));
      end else if (run_q) begin
        if (ge) rem_q <= rem_q - dsh_q;
        quo_q <= {quo_q[Q_W-2:0], ge};
        dsh_q <= dsh_q >> 1;
        cnt_q <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
          // Saturated results override whatever the iterations produced.
          if (sat_q) quo_q <= '1;
        end
      end
    end
  end
endmodule

// File: rtl/awb_gain_est.sv
// Gray-world AWB gain estimator: per-channel frame sums/counts, then K_R/K_B vs green.
// Optional manual override of K_R/K_B when AWB_MANUAL_GAIN_EN is defined.
module awb_gain_est
  import awb_pkg::*;
#(
  parameter int ACC_W     = DEF_ACC_W,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic              clk,
  input  logic              rst,
  awb_gain_est_if.slave     px,
  output logic [GAIN_W-1:0] K_R,
  output logic [GAIN_W-1:0] K_G,
  output logic [GAIN_W-1:0] K_B,
  output logic              valid_gain_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              drop_o
`ifdef AWB_MANUAL_GAIN_EN
  ,
  input  logic              man_en_i,
  input  logic [GAIN_W-1:0] man_kr_i,
  input  logic [GAIN_W-1:0] man_kb_i
`endif
);
  localparam int NUM_W = ACC_W + CNT_W + FRAC_BITS;
  localparam int DEN_W = ACC_W + CNT_W;
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(unity_gain(FRAC_BITS));

  logic [ACC_W-1:0] sum_q [3];
  logic [ACC_W-1:0] sum_d [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [ACC_W-1:0] snap_sum_q [3];
  logic [CNT_W-1:0] snap_cnt_q [3];

  awb_state_e        state_q;
  logic              busy_q, done_q, drop_q, start_q, valid_q;
  logic [NUM_W-1:0]  num_r_q, num_b_q, num_r_d, num_b_d;
  logic [DEN_W-1:0]  den_r_q, den_b_q, den_r_d, den_b_d;
  logic [GAIN_W-1:0] kr_tmp_q, kr_q, kb_q;
  logic              discard;

  logic              div_start, div_done;
  logic [NUM_W-1:0]  div_num;
  logic [DEN_W-1:0]  div_den;
  logic [GAIN_W-1:0] div_quo;

  // frame_start_i restarts the running totals so a coincident pixel becomes the first one.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic             hit;
      logic [ACC_W-1:0] sum_base;
      logic [CNT_W-1:0] cnt_base;
      logic [ACC_W:0]   sum_add;
      logic [CNT_W:0]   cnt_add;

      assign hit      = px.valid_i && (px.color_i == 2'(gi));
      assign sum_base = px.frame_start_i ? '0 : sum_q[gi];
      assign cnt_base = px.frame_start_i ? '0 : cnt_q[gi];
      assign sum_add  = {1'b0, sum_base} + (ACC_W + 1)'(px.value_i);
      assign cnt_add  = {1'b0, cnt_base} + (CNT_W + 1)'(1);
      assign sum_d[gi] = !hit ? sum_base : (sum_add[ACC_W] ? '1 : sum_add[ACC_W-1:0]);
      assign cnt_d[gi] = !hit ? cnt_base : (cnt_add[CNT_W] ? '1 : cnt_add[CNT_W-1:0]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        sum_q[c]      <= '0;
        cnt_q[c]      <= '0;
        snap_sum_q[c] <= '0;
        snap_cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < 3; c++) begin
        sum_q[c] <= px.frame_end_i ? '0 : sum_d[c];
        cnt_q[c] <= px.frame_end_i ? '0 : cnt_d[c];
        if (px.frame_end_i && !busy_q) begin
          snap_sum_q[c] <= sum_d[c];
          snap_cnt_q[c] <= cnt_d[c];
        end
      end
    end
  end

  assign num_r_d = (NUM_W'(snap_sum_q[GREEN]) * NUM_W'(snap_cnt_q[RED]))  << FRAC_BITS;
  assign num_b_d = (NUM_W'(snap_sum_q[GREEN]) * NUM_W'(snap_cnt_q[BLUE])) << FRAC_BITS;
  assign den_r_d = DEN_W'(snap_sum_q[RED])  * DEN_W'(snap_cnt_q[GREEN]);
  assign den_b_d = DEN_W'(snap_sum_q[BLUE]) * DEN_W'(snap_cnt_q[GREEN]);
  assign discard = (snap_sum_q[GREEN] == '0) || (snap_cnt_q[RED] == '0) ||
                   (snap_cnt_q[GREEN] == '0) || (snap_cnt_q[BLUE] == '0);

  // B is launched in the same cycle R finishes so both gains fit the fixed latency.
  assign div_start = start_q || ((state_q == ST_DIV_R) && div_done);
  assign div_num   = start_q ? num_r_q : num_b_q;
  assign div_den   = start_q ? den_r_q : den_b_q;

  awb_div #(
    .NUM_W (NUM_W),
    .DEN_W (DEN_W),
    .Q_W   (GAIN_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .num_i   (div_num),
    .den_i   (div_den),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      drop_q   <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      num_r_q  <= '0;
      num_b_q  <= '0;
      den_r_q  <= '0;
      den_b_q  <= '0;
      kr_tmp_q <= UNITY;
      kr_q     <= UNITY;
      kb_q     <= UNITY;
    end else begin
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      start_q <= 1'b0;
      if (px.frame_end_i && busy_q) drop_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (px.frame_end_i) begin
            state_q <= ST_MUL;
            busy_q  <= 1'b1;
          end
        end
        ST_MUL: begin
          num_r_q <= num_r_d;
          num_b_q <= num_b_d;
          den_r_q <= den_r_d;
          den_b_q <= den_b_d;
          if (discard) begin
            drop_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            start_q <= 1'b1;
            state_q <= ST_DIV_R;
          end
        end
        ST_DIV_R: begin
          if (div_done) begin
            kr_tmp_q <= div_quo;
            state_q  <= ST_DIV_B;
          end
        end
        ST_DIV_B: begin
          if (div_done) state_q <= ST_COMMIT;
        end
        ST_COMMIT: begin
          kr_q    <= kr_tmp_q;
          kb_q    <= div_quo;
          done_q  <= 1'b1;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign K_G    = UNITY;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign drop_o = drop_q;

`ifdef AWB_MANUAL_GAIN_EN
  logic              man_en_q;
  logic [GAIN_W-1:0] man_kr_q, man_kb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      man_en_q <= 1'b0;
      man_kr_q <= UNITY;
      man_kb_q <= UNITY;
    end else begin
      man_en_q <= man_en_i;
      man_kr_q <= man_kr_i;
      man_kb_q <= man_kb_i;
    end
  end

  assign K_R          = man_en_q ? man_kr_q : kr_q;
  assign K_B          = man_en_q ? man_kb_q : kb_q;
  assign valid_gain_o = valid_q | man_en_q;
`else
  assign K_R          = kr_q;
  assign K_B          = kb_q;
  assign valid_gain_o = valid_q;
`endif
endmodule

// File: tb/tb_awb_gain_est.sv
// Directed bench for awb_gain_est: 4x4 RGGB frames with hand-computed gains.
module tb_awb_gain_est;
  import awb_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] K_R, K_G, K_B;
  logic       valid_gain_o, busy_o, done_o, drop_o;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         lat;
  int         drop_k;
  int         done_k;

  awb_gain_est_if px ();

  awb_gain_est dut (
    .clk          (clk),
    .rst          (rst),
    .px           (px),
    .K_R          (K_R),
    .K_G          (K_G),
    .K_B          (K_B),
    .valid_gain_o (valid_gain_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .drop_o       (drop_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
    $display("check %-14s observed %0d expected %0d", tag, obs, exp);
  endtask

  // RGGB 4x4: even rows R,G,R,G; odd rows G,B,G,B. Returns one cycle after the frame_end edge.
  task automatic send_frame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    for (int i = 0; i < 16; i++) begin
      logic [1:0] col;
      int row;
      row = i / 4;
      if (row % 2 == 0) col = (i % 2 == 0) ? 2'd0 : 2'd1;
      else              col = (i % 2 == 0) ? 2'd1 : 2'd2;
      @(negedge clk);
      px.valid_i       = 1'b1;
      px.color_i       = col;
      px.value_i       = (col == 2'd0) ? r : (col == 2'd1) ? g : b;
      px.frame_start_i = (i == 0);
      px.frame_end_i   = (i == 15);
    end
    @(posedge clk);
    #1;
    px.valid_i       = 1'b0;
    px.frame_start_i = 1'b0;
    px.frame_end_i   = 1'b0;
    $display("frame sent r=%0d g=%0d b=%0d busy=%0d", r, g, b, busy_o);
  endtask

  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    px.valid_i       = 1'b0;
    px.color_i       = 2'd0;
    px.value_i       = 8'd0;
    px.frame_start_i = 1'b0;
    px.frame_end_i   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_K_R", K_R, UNITY_GAIN);
    check("rst_K_G", K_G, UNITY_GAIN);
    check("rst_K_B", K_B, UNITY_GAIN);
    check("rst_valid", valid_gain_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_drop", drop_o, 0);
    @(negedge clk);
    rst = 1'b0;

    // Flat gray frame: unity gains after 21 cycles.
    send_frame(8'd100, 8'd100, 8'd100);
    check("flat_busy", busy_o, 1);
    wait_done(lat);
    check("flat_latency", lat, 21);
    check("flat_K_R", K_R, 1);
    check("flat_K_G", K_G, 1);
    check("flat_K_B", K_B, 1);
    check("flat_valid", valid_gain_o, 1);
    @(posedge clk);
    #1;
    check("flat_done_pls", done_o, 0);
    check("flat_busy_end", busy_o, 0);

    send_frame(8'd50, 8'd100, 8'd25);
    wait_done(lat);
    check("rgb_latency", lat, 21);
    check("rgb_K_R", K_R, 2);
    check("rgb_K_B", K_B, 4);

    // Zero red sum: divider saturates.
    send_frame(8'd0, 8'd100, 8'd100);
    wait_done(lat);
    check("sat_latency", lat, 21);
    check("sat_K_R", K_R, 255);
    check("sat_K_B", K_B, 1);

    // Zero green sum: frame discarded, previous gains kept.
    send_frame(8'd100, 8'd0, 8'd100);
    drop_k = -1;
    done_k = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (drop_o && drop_k < 0) drop_k = k;
      if (done_o && done_k < 0) done_k = k;
    end
    check("g0_drop_cycle", drop_k, 1);
    check("g0_no_done", done_k, -1);
    check("g0_K_R", K_R, 255);
    check("g0_K_B", K_B, 1);
    check("g0_valid", valid_gain_o, 1);
    check("g0_busy", busy_o, 0);

    // Second frame_end five cycles into the compute is dropped; first result still commits.
    send_frame(8'd50, 8'd100, 8'd25);
    drop_k = -1;
    done_k = -1;
    for (int k = 1; k <= 40 && done_k < 0; k++) begin
      @(posedge clk);
      #1;
      if (drop_o && drop_k < 0) drop_k = k;
      if (done_o) done_k = k;
      px.frame_end_i = (k == 4);
    end
    px.frame_end_i = 1'b0;
    check("busy_drop_cyc", drop_k, 5);
    check("busy_done_cyc", done_k, 21);
    check("busy_K_R", K_R, 2);
    check("busy_K_B", K_B, 4);

    // Asynchronous reset while dividing the blue gain.
    send_frame(8'd100, 8'd100, 8'd100);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    check("midrst_busy_pre", busy_o, 1);
    rst = 1'b1;
    #1;
    check("midrst_K_R", K_R, 1);
    check("midrst_K_B", K_B, 1);
    check("midrst_valid", valid_gain_o, 0);
    check("midrst_busy", busy_o, 0);
    @(negedge clk);
    rst = 1'b0;

    send_frame(8'd50, 8'd100, 8'd25);
    wait_done(lat);
    check("post_latency", lat, 21);
    check("post_K_R", K_R, 2);
    check("post_K_B", K_B, 4);
    check("post_valid", valid_gain_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
